layer_decoder: RTL

Converts the per-neuron output bitstreams of a neuron layer into unsigned ones-counts over a fixed observation window, one count per neuron. Sits directly downstream of the layer: its `bitstream_in` bus is the layer's `layer_output` bus. It discards a programmable warm-up period, counts ones for exactly 2^WINDOW_BITS cycles, then presents all counts together behind a valid/ready handshake for readout or the next layer's encoder.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/bit_accumulator.sv | 31 +++
 rtl/layer_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and limits for the layer decoder.
//   decoder_state_t : measurement FSM states
//   MAX_WARMUP      : largest supported warm-up length (8-bit warm-up counter)
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    COUNT  = 2'd2,
    VALID  = 2'd3
  } decoder_state_t;

  localparam int unsigned MAX_WARMUP = 255;

endpackage

// File: rtl/bit_accumulator.sv
// Ones-counter for a single bitstream.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears acc
//   clear  : synchronous clear, takes priority over enable
//   enable : add bit_in to acc this cycle
//   bit_in : stochastic input bit
//   acc    : running ones-count
module bit_accumulator #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= acc_q + {{(WIDTH-1){1'b0}}, bit_in};
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/layer_decoder.sv
// Converts per-neuron bitstreams into ones-counts over a 2^WINDOW_BITS cycle
// window after a WARMUP-cycle discard period, then holds all counts behind a
// valid/ready handshake.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   start        : begin a measurement (IDLE, or VALID on handshake)
//   bitstream_in : one bit per neuron per cycle
//   counts       : per-neuron ones-count of the last completed window
//   out_valid    : counts holds a completed result
//   out_ready    : consumer accepts counts
//   busy         : measurement in progress (warm-up or counting)
module layer_decoder
  import decoder_pkg::decoder_state_t, decoder_pkg::MAX_WARMUP;
#(
  parameter int unsigned NEURON_COUNT = 2,
  parameter int unsigned WINDOW_BITS  = 8,
  parameter int unsigned WARMUP       = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [NEURON_COUNT-1:0]                bitstream_in,
  output logic [NEURON_COUNT-1:0][WINDOW_BITS:0] counts,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy
);

  localparam int unsigned WARMUP_CYC = (WARMUP > MAX_WARMUP) ? MAX_WARMUP : WARMUP;
  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYC - 1);
  localparam logic [WINDOW_BITS:0] WIN_LAST = {1'b0, {WINDOW_BITS{1'b1}}};
  localparam decoder_state_t FIRST_STATE =
    (WARMUP_CYC == 0) ? decoder_pkg::COUNT : decoder_pkg::WARMUP;

  decoder_state_t state_q, state_d;
  logic [7:0]           warm_q, warm_d;
  logic [WINDOW_BITS:0] cyc_q, cyc_d;
  logic [NEURON_COUNT-1:0][WINDOW_BITS:0] counts_q;
  logic [NEURON_COUNT-1:0][WINDOW_BITS:0] acc;
  logic [NEURON_COUNT-1:0][WINDOW_BITS:0] final_sum;
  logic out_valid_q, busy_q;
  logic acc_clear, acc_enable, load_counts;

  for (genvar i = 0; i < NEURON_COUNT; i++) begin : g_acc
    bit_accumulator #(
      .WIDTH(WINDOW_BITS + 1)
    ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clear (acc_clear),
      .enable(acc_enable),
      .bit_in(bitstream_in[i]),
      .acc   (acc[i])
    );
    // The last sampled bit is still in flight when the window closes, so the
    // result register takes accumulator plus the current bit.
    assign final_sum[i] = acc[i] + {{WINDOW_BITS{1'b0}}, bitstream_in[i]};
  end

  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    cyc_d       = cyc_q;
    acc_clear   = 1'b0;
    acc_enable  = 1'b0;
    load_counts = 1'b0;
    unique case (state_q)
      decoder_pkg::IDLE: begin
        if (start) begin
          acc_clear = 1'b1;
          warm_d    = '0;
          cyc_d     = '0;
          state_d   = FIRST_STATE;
        end
      end
      decoder_pkg::WARMUP: begin
        warm_d = warm_q + 8'd1;
        if (warm_q == WARM_LAST) begin
          state_d = decoder_pkg::COUNT;
        end
      end
      decoder_pkg::COUNT: begin
        acc_enable = 1'b1;
        cyc_d      = cyc_q + 1'b1;
        if (cyc_q == WIN_LAST) begin
          load_counts = 1'b1;
          state_d     = decoder_pkg::VALID;
        end
      end
      decoder_pkg::VALID: begin
        if (out_ready) begin
          if (start) begin
            acc_clear = 1'b1;
            warm_d    = '0;
            cyc_d     = '0;
            state_d   = FIRST_STATE;
          end else begin
            state_d = decoder_pkg::IDLE;
          end
        end
      end
      default: state_d = decoder_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= decoder_pkg::IDLE;
      warm_q      <= '0;
      cyc_q       <= '0;
      counts_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      cyc_q       <= cyc_d;
      if (load_counts) begin
        counts_q <= final_sum;
      end
      out_valid_q <= (state_d == decoder_pkg::VALID);
      busy_q      <= (state_d == decoder_pkg::WARMUP) || (state_d == decoder_pkg::COUNT);
    end
  end

  assign counts    = counts_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
